// File: rtl/heap_pkg.sv
// Shared definitions for the min-heap sift-down pipeline.
//   EMPTY_KEY : all-ones key, treated as +infinity (empty slot)
//   state_t   : sift node FSM encoding
//   token_t   : replace token passed between levels (default widths)
package heap_pkg;

  localparam int KEY_W = 32;
  localparam int IDX_W = 6;

  localparam logic [KEY_W-1:0] EMPTY_KEY = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    SEND = 2'd3
  } state_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [IDX_W-1:0] idx;
  } token_t;

endpackage

// File: rtl/heap_sift_node_if.sv
// Bundle of all non-clock signals of one sift node.
//   in_*   : token from level L-1 node (valid/ready)
//   out_*  : token to level L+1 node (valid/ready)
//   ch_addr, lm_dout, rm_dout : child read port on level L+1 store
//   nl_*   : own-slot write port on level L store
// slave = the node, master = its environment.
interface heap_sift_node_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_key;
  logic [ADDR_WIDTH:0]   in_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_key;
  logic [ADDR_WIDTH:0]   out_idx;
  logic [ADDR_WIDTH-1:0] ch_addr;
  logic [DATA_WIDTH-1:0] lm_dout;
  logic [DATA_WIDTH-1:0] rm_dout;
  logic [ADDR_WIDTH-1:0] nl_addr;
  logic                  nl_branch;
  logic                  nl_we;
  logic [DATA_WIDTH-1:0] nl_din;

  modport slave (
    input  in_valid, in_key, in_idx, out_ready, lm_dout, rm_dout,
    output in_ready, out_valid, out_key, out_idx, ch_addr,
           nl_addr, nl_branch, nl_we, nl_din
  );

  modport master (
    output in_valid, in_key, in_idx, out_ready, lm_dout, rm_dout,
    input  in_ready, out_valid, out_key, out_idx, ch_addr,
           nl_addr, nl_branch, nl_we, nl_din
  );
endinterface

// File: rtl/heap_min2.sv
// Combinational unsigned min of two keys.
//   a, b : left / right candidate
//   min  : smaller value
//   sel  : 0 = left won, 1 = right won (ties go left)
module heap_min2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] min,
  output logic             sel
);
  assign sel = (b < a);
  assign min = sel ? b : a;
endmodule

// File: rtl/heap_sift_node.sv
// One sift-down stage of the hardware min-heap (level LEVEL).
//   clk, rst_n : clock, async active-low reset
//   bus        : token in/out, child read port, own-slot write port
// Accepts (key K, slot I), reads children 2I/2I+1 (bank addr I), writes
// min(K, min child) into slot I and forwards K downwards when it must sink.
module heap_sift_node
  import heap_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LEVEL      = 1,
  parameter int IS_LEAF    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  heap_sift_node_if.slave bus
);

  // Slot index within level L only uses LEVEL bits.
  localparam logic [ADDR_WIDTH:0] IDX_MASK =
    (ADDR_WIDTH+1)'((64'd1 << LEVEL) - 64'd1);

  state_t                state;
  logic [DATA_WIDTH-1:0] k_q;
  logic [ADDR_WIDTH:0]   i_q;
  logic                  sink_q;
  logic [ADDR_WIDTH:0]   idx_m;
  logic [DATA_WIDTH-1:0] m_min;
  logic                  sel_min;

  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_key_q;
  logic [ADDR_WIDTH:0]   out_idx_q;
  logic [ADDR_WIDTH-1:0] nl_addr_q;
  logic                  nl_branch_q;
  logic                  nl_we_q;
  logic [DATA_WIDTH-1:0] nl_din_q;

  assign idx_m = bus.in_idx & IDX_MASK;

  heap_min2 #(.WIDTH(DATA_WIDTH)) u_min (
    .a   (bus.lm_dout),
    .b   (bus.rm_dout),
    .min (m_min),
    .sel (sel_min)
  );

  // The child store registers its address on the accept edge, so the
  // address must come straight from in_idx while IDLE for the data to be
  // present in RD.
  assign bus.ch_addr = (IS_LEAF != 0)  ? '0 :
                       (state == IDLE) ? idx_m[ADDR_WIDTH-1:0]
                                       : i_q[ADDR_WIDTH-1:0];

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_key   = out_key_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.nl_addr   = nl_addr_q;
  assign bus.nl_branch = nl_branch_q;
  assign bus.nl_we     = nl_we_q;
  assign bus.nl_din    = nl_din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k_q         <= '0;
      i_q         <= '0;
      sink_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_key_q   <= '0;
      out_idx_q   <= '0;
      nl_addr_q   <= '0;
      nl_branch_q <= 1'b0;
      nl_we_q     <= 1'b0;
      nl_din_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            k_q         <= bus.in_key;
            i_q         <= idx_m;
            in_ready_q  <= 1'b0;
            nl_addr_q   <= ADDR_WIDTH'(idx_m >> 1);
            nl_branch_q <= idx_m[0];
            if (IS_LEAF != 0) begin
              // Leaf: nothing below, key always stays.
              nl_we_q  <= 1'b1;
              nl_din_q <= bus.in_key;
              sink_q   <= 1'b0;
              state    <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          // Decision is registered here so WR drives only flops.
          // EMPTY_KEY needs no special case: all-ones is the largest value.
          nl_we_q <= 1'b1;
          state   <= WR;
          if (k_q <= m_min) begin
            nl_din_q <= k_q;
            sink_q   <= 1'b0;
          end else begin
            nl_din_q  <= m_min;
            sink_q    <= 1'b1;
            out_key_q <= k_q;
            out_idx_q <= (ADDR_WIDTH+1)'({i_q, sel_min});
          end
        end
        WR: begin
          nl_we_q <= 1'b0;
          if (sink_q) begin
            out_valid_q <= 1'b1;
            state       <= SEND;
          end else begin
            in_ready_q <= 1'b1;
            state      <= IDLE;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/heap_sift_node.md
Name: heap_sift_node

Overview:
- One pipelined sift-down stage of the hardware min-heap. There is one instance per heap level L.
- It accepts a replace token (key, slot index) from the level L-1 node.
- It reads the two children of that slot from level L+1 storage through the lm/rm ports of the level L+1 data_store.
- It writes the winning key into its own slot through the nl port of the level L data_store. If the key must sink further, it forwards a token to the level L+1 node.

Parameters:
DATA_WIDTH, 32, key width; all-ones marks an empty slot
ADDR_WIDTH, 5, bank address width of the attached data_stores
LEVEL, 1, heap level L of this node; slot index uses LEVEL bits
IS_LEAF, 0, 1 = last level: no child reads, no downstream token

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  token from level L-1 node
in_ready  out  1  node can accept a token
in_key  in  DATA_WIDTH  key to place at slot in_idx
in_idx  in  ADDR_WIDTH+1  slot index within level L
out_valid  out  1  token to level L+1 node
out_ready  in  1  level L+1 node accepts
out_key  out  DATA_WIDTH  key that continues sinking
out_idx  out  ADDR_WIDTH+1  child slot index at level L+1
ch_addr  out  ADDR_WIDTH  drives lm_addr and rm_addr of level L+1 store (lm_we/rm_we tied 0)
lm_dout  in  DATA_WIDTH  left child key
rm_dout  in  DATA_WIDTH  right child key
nl_addr  out  ADDR_WIDTH  own-slot address to level L store
nl_branch  out  1  own-slot bank select
nl_we  out  1  own-slot write strobe
nl_din  out  DATA_WIDTH  own-slot write data

Behaviour:
- Reset: every output is 0 except in_ready, which is 1. The FSM resets to IDLE. A reset asserted mid-operation aborts the token: no write is issued and no out_valid is raised.
- Address mapping:
  - Own slot i: nl_branch = i[0], nl_addr = i >> 1.
  - Children of i are 2i (left bank) and 2i+1 (right bank), both at bank address i, so ch_addr = i.
- FSM IDLE:
  - in_ready = 1. On in_valid, capture key K and index I, drive ch_addr = I, go to RD.
  - If IS_LEAF = 1, go to WR instead.
- FSM RD:
  - Child data is valid this cycle (the store has 1-cycle read latency).
  - Compute m = min(lm_dout, rm_dout), unsigned compare. A tie selects the left child; sel = 0 for left, 1 for right.
  - Register K, m and sel. Go to WR.
- FSM WR:
  - nl_we = 1 for exactly one cycle.
  - If IS_LEAF = 1 or K <= m (unsigned): nl_din = K. Go to IDLE; no token is forwarded.
  - Otherwise: nl_din = m; out_key = K; out_idx = {I, sel}. Go to SEND.
- FSM SEND:
  - out_valid = 1. out_key and out_idx are held stable until out_ready is sampled high, then go to IDLE.
  - in_ready = 0 in every state except IDLE.
- Latency:
  - Accept to own-slot write: 2 cycles.
  - Accept to out_valid: 3 cycles.
  - Throughput: one token per 3 cycles, plus any downstream stall.
- Empty slots: the all-ones key behaves as +infinity.
  - Two empty children with K below all-ones: K stays in place.
  - K = all-ones (a delete filler) sinks until both children are empty or the node is a leaf.
- Write conflicts: the level L store gives the upper node's lm/rm write priority over nl. The controller must not issue a token to L-1 that targets the same slot in the same cycle. This node performs no arbitration.
- in_idx bits above LEVEL are ignored. out_idx uses LEVEL+1 bits.

Decomposition:
- Shared package heap_pkg:
  - EMPTY_KEY = all-ones constant.
  - FSM state encoding: IDLE=0, RD=1, WR=2, SEND=3.
  - Token struct fields: key and idx.
- Natural sub-module: heap_min2, a combinational unsigned min-of-two that returns value and sel, with ties going left. The node instantiates it once.

Test Plan:
- Reset: hold rst_n=0 -> in_ready=1, out_valid=0, nl_we=0. Assert rst_n in the middle of RD -> no nl_we, and out_valid stays 0.
- Stay, LEVEL=2: in_key=5, in_idx=3, lm=7, rm=9 -> WR cycle with nl_addr=1, nl_branch=1, nl_din=5; no out_valid.
- Sink right: in_key=20, in_idx=2, lm=12, rm=8 -> nl_din=8; out_valid with out_key=20, out_idx=5. Hold out_ready=0 for 4 cycles -> outputs stable and in_ready=0.
- Tie and empty children: lm=rm=4, in_key=6 -> nl_din=4, out_idx={I,0}. Then lm=rm=all-ones, in_key=6 -> stay, no token.
- Leaf, IS_LEAF=1: in_key=3, in_idx=6 -> nl_we asserted 1 cycle after accept, nl_addr=3, nl_branch=0; out_valid never rises.
- Back-to-back: two tokens offered continuously -> the second is accepted 3 cycles after the first (with out_ready=1). Writes are ordered and no token is lost.
